// File: rtl/ex_stage.sv
// Execute stage: drives the combinational ALU, resolves bne/blt and registers the X/M latch.
// Optional macro EX_OVF_EXCEPTION_EN enables overflow-exception rewriting into RSTATUS_REG.

module alu (
    input  logic [31:0] i_operand_a,
    input  logic [31:0] i_operand_b,
    input  logic [4:0]  i_opcode,
    input  logic [4:0]  i_shamt,
    output logic [31:0] o_result,
    output logic        o_not_equal,
    output logic        o_less_than,
    output logic        o_overflow
);
    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        case (i_opcode)
            5'd0: begin
                o_result   = i_operand_a + i_operand_b;
                o_overflow = (i_operand_a[31] == i_operand_b[31]) && (o_result[31] != i_operand_a[31]);
            end
            5'd1: begin
                o_result   = i_operand_a - i_operand_b;
                o_overflow = (i_operand_a[31] != i_operand_b[31]) && (o_result[31] != i_operand_a[31]);
            end
            5'd2:    o_result = i_operand_a & i_operand_b;
            5'd3:    o_result = i_operand_a | i_operand_b;
            5'd4:    o_result = i_operand_a << i_shamt;
            5'd5:    o_result = $signed(i_operand_a) >>> i_shamt;
            default: o_result = '0;
        endcase
    end

    assign o_not_equal = (i_operand_a != i_operand_b);
    assign o_less_than = ($signed(i_operand_a) < $signed(i_operand_b));
endmodule

module ex_stage #(
    parameter int unsigned RSTATUS_REG = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_kind,
    input  logic [4:0]  in_aluop,
    input  logic [4:0]  in_shamt,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_pc,
    input  logic        in_flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_wen,
    output logic        out_exc,
    output logic        out_br_taken,
    output logic [31:0] out_br_target
);
`ifdef EX_OVF_EXCEPTION_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        KIND_ALU  = 3'd0,
        KIND_ADDI = 3'd1,
        KIND_BNE  = 3'd2,
        KIND_BLT  = 3'd3
    } kind_t;

    logic [4:0]  w_aluop;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_result;
    logic        w_not_equal;
    logic        w_less_than;
    logic        w_alu_ovf;

    logic [31:0] w_result;
    logic [4:0]  w_rd;
    logic        w_wen;
    logic        w_exc;
    logic        w_taken;
    logic        w_ovf_chk;
    logic [31:0] w_ovf_code;
    logic [31:0] w_target;
    logic        w_accept;

    logic        r_valid;
    logic [31:0] r_result;
    logic [4:0]  r_rd;
    logic        r_wen;
    logic        r_exc;
    logic        r_taken;
    logic [31:0] r_target;

    always_comb begin
        w_aluop = in_aluop;
        w_alu_b = in_b;
        case (kind_t'(in_kind))
            KIND_ADDI: begin
                w_aluop = 5'd0;
                w_alu_b = in_imm;
            end
            KIND_BNE, KIND_BLT: w_aluop = 5'd1;
            default: ;
        endcase
    end

    alu u_alu (
        .i_operand_a (in_a),
        .i_operand_b (w_alu_b),
        .i_opcode    (w_aluop),
        .i_shamt     (in_shamt),
        .o_result    (w_alu_result),
        .o_not_equal (w_not_equal),
        .o_less_than (w_less_than),
        .o_overflow  (w_alu_ovf)
    );

    assign w_target = in_pc + 32'd1 + in_imm;

    always_comb begin
        w_result   = w_alu_result;
        w_rd       = in_rd;
        w_wen      = (in_rd != '0);
        w_exc      = 1'b0;
        w_taken    = 1'b0;
        w_ovf_chk  = 1'b0;
        w_ovf_code = 32'd1;
        case (kind_t'(in_kind))
            KIND_ALU: begin
                if (in_aluop > 5'd5) begin
                    w_result = '0;
                    w_wen    = 1'b0;
                end else if (in_aluop == 5'd0 || in_aluop == 5'd1) begin
                    w_ovf_chk  = 1'b1;
                    w_ovf_code = (in_aluop == 5'd0) ? 32'd1 : 32'd3;
                end
            end
            KIND_ADDI: begin
                w_ovf_chk  = 1'b1;
                w_ovf_code = 32'd2;
            end
            KIND_BNE: begin
                w_rd    = '0;
                w_wen   = 1'b0;
                w_taken = w_not_equal;
            end
            KIND_BLT: begin
                w_rd    = '0;
                w_wen   = 1'b0;
                w_taken = w_less_than;
            end
            default: w_result = in_a;
        endcase
        // Exception rewrite redirects the write to the status register with a cause code.
        if (OVF_EN && w_ovf_chk && w_alu_ovf) begin
            w_result = w_ovf_code;
            w_rd     = 5'(RSTATUS_REG);
            w_wen    = 1'b1;
            w_exc    = 1'b1;
        end
    end

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready && !in_flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_rd     <= '0;
            r_wen    <= 1'b0;
            r_exc    <= 1'b0;
            r_taken  <= 1'b0;
            r_target <= '0;
        end else if (in_flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_result <= w_result;
            r_rd     <= w_rd;
            r_wen    <= w_wen;
            r_exc    <= w_exc;
            r_taken  <= w_taken;
            r_target <= w_target;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid     = r_valid;
    assign out_result    = r_result;
    assign out_rd        = r_rd;
    assign out_wen       = r_wen;
    assign out_exc       = r_exc;
    assign out_br_taken  = r_taken;
    assign out_br_target = r_target;
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute pipeline stage that feeds the combinational `alu` and registers its result into the X/M latch. It sits between the decode/operand-fetch stage and the memory/writeback stages. It selects the ALU opcode and operands by instruction kind, resolves `bne`/`blt` branches, and applies overflow-exception rewriting. It uses a valid/ready handshake on both sides so downstream stalls propagate upstream.

## Interface
Parameters:
- `RSTATUS_REG`, default 30: register index written on an overflow exception.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: decode presents an instruction.
- `in_ready` out 1: stage can accept this cycle.
- `in_kind` in 3: 0=ALU R-type, 1=ADDI, 2=BNE, 3=BLT, 4–7=PASS (result = operand A).
- `in_aluop` in 5: ALU opcode for R-type.
- `in_shamt` in 5: shift amount.
- `in_rd` in 5: destination register.
- `in_a`, `in_b` in 32: operands, with rs→A and rt/rd→B.
- `in_imm` in 32: sign-extended immediate.
- `in_pc` in 32: PC of the instruction.
- `in_flush` in 1: kill the held output and any same-cycle input.
- `out_valid` out 1: X/M latch holds a valid instruction.
- `out_ready` in 1: downstream accepts.
- `out_result` out 32: registered result.
- `out_rd` out 5: registered destination.
- `out_wen` out 1: register writeback enable.
- `out_exc` out 1: overflow exception occurred.
- `out_br_taken` out 1: branch resolved taken.
- `out_br_target` out 32: branch target.

## Operation
- Accept condition: `in_valid && in_ready && !in_flush`, with `in_ready = !out_valid || out_ready`.
- ALU drive by kind:
  - ALU: aluop = `in_aluop`, B = `in_b`.
  - ADDI: aluop = 00000, B = `in_imm`.
  - BNE/BLT: aluop = 00001 (sub), B = `in_b`.
  - PASS: ALU unused.
  - `ctrl_shiftamt` = `in_shamt` for all kinds.
- Legal R-type aluops are 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll, 00101 sra.
  - aluop 00110–11111: result forced to 0 and `wen` = 0. The stage never latches the ALU's undriven bus.
- Writeback:
  - ALU/ADDI/PASS: `wen` = (`rd` != 0).
  - BNE/BLT: `wen` = 0 and `out_rd` = 0.
- Branch resolution:
  - BNE is taken when `isNotEqual`.
  - BLT is taken when `isLessThan`, meaning A < B signed.
  - target = `in_pc` + 1 + `in_imm`, modulo 2^32. It is computed for every kind.
  - `out_br_taken` is 0 for non-branches.
- Overflow on R-type add/sub and ADDI (see Configuration):
  - `out_rd` = `RSTATUS_REG`, `wen` = 1, `out_exc` = 1.
  - result = 1 for add, 2 for addi, 3 for sub.
- Output register update priority, per clock:
  1. `in_flush` clears `out_valid` to 0 and drops any input.
  2. Otherwise, on accept, all `out_*` load and `out_valid` = 1.
  3. Otherwise, if `out_ready`, `out_valid` = 0.
  4. Otherwise, hold all outputs.
- Simultaneous `out_ready` and accept while full: the old entry retires and the new one loads in the same edge. This gives full throughput.

## Timing
- Latency is 1 cycle: an input accepted at edge N appears on `out_*` after edge N.
- Throughput is 1/cycle when `out_ready` is held high.
- `in_ready` is combinational from `out_valid` and `out_ready`. No other output is combinational.
- Reset values, applied immediately on `reset` assertion mid-cycle: `out_valid` = 0, `out_result` = 0, `out_rd` = 0, `out_wen` = 0, `out_exc` = 0, `out_br_taken` = 0, `out_br_target` = 0.
- While `out_valid` = 1 and `out_ready` = 0, all `out_*` hold stable.
- `in_flush` and `reset` both override a pending accept in the same cycle.

## Configuration
- `EX_OVF_EXCEPTION_EN` defined: overflow rewriting applies as described in Operation.
- `EX_OVF_EXCEPTION_EN` undefined:
  - `out_exc` is tied 0.
  - add/sub/addi store the wrapped 32-bit sum to the original `rd`.
  - `RSTATUS_REG` is unused.

## Test plan
- Reset, then ADDI with A=5, imm=−3, rd=4 → one cycle later `out_valid`=1, `out_result`=2, `out_rd`=4, `out_wen`=1.
- R-type add with A=0x7FFFFFFF, B=1, rd=7:
  - with the macro: `out_rd`=30, `out_result`=1, `out_exc`=1.
  - without the macro: `out_rd`=7, `out_result`=0x80000000, `out_exc`=0.
- BLT with A=−2, B=3, pc=0x10, imm=4 → `out_br_taken`=1, `out_br_target`=0x15, `out_wen`=0. BNE with A=B=9 → `out_br_taken`=0.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 and outputs stable. Raise `out_ready` → old entry retires and the next entry loads on the same edge.
- Assert `in_flush` with `out_valid`=1 and `in_valid`=1 → next cycle `out_valid`=0 and the input is not captured.
- R-type aluop 00111 → `out_result`=0, `out_wen`=0. Assert `reset` mid-cycle while `out_valid`=1 → `out_valid` drops to 0 before the next edge.
